// File: rtl/ac_scan_pkg.sv
// Shared constants for the AC scan reader: progressive ProRes scan table and FSM states.
package ac_scan_pkg;

    localparam int COEF_PER_BLOCK = 64;

    localparam logic [5:0] SCAN [COEF_PER_BLOCK] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    function automatic logic [5:0] scan_pos(input logic [5:0] coef);
        return SCAN[coef];
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head.
module sync_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o
);
    logic [1:0][W-1:0] ent_q, ent_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        wr_sel;
    logic              pop, push;

    assign pop    = pop_i && (cnt_q != 2'd0);
    assign push   = push_i && ((cnt_q != 2'd2) || pop);
    assign wr_sel = cnt_q - {1'b0, pop};

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        if (pop)  ent_d[0] = ent_q[1];
        // Write lands behind whatever survives this cycle's pop.
        if (push) ent_d[wr_sel[0]] = din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout_o  = ent_q[0];
    assign count_o = cnt_q;

endmodule

// File: rtl/ac_scan_reader.sv
// Walks a slice's coefficient RAM in AC entropy order (coef-major, block-minor)
// and streams each word with its scan index, block index and last flag.
module ac_scan_reader
    import ac_scan_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_BLOCKS = 32,
    parameter int ADDR_W     = 11,
    parameter int FIRST_COEF = 1,
    localparam int BLK_W     = $clog2(MAX_BLOCKS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       block_num_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [5:0]        out_coef_o,
    output logic [BLK_W-1:0]  out_block_o,
    output logic              out_last_o
);
    localparam int NB_W  = BLK_W + 1;
    localparam int TAG_W = 1 + BLK_W + 6;
    localparam int PAY_W = TAG_W + DATA_W;

    state_e            state_q, state_d;
    logic [NB_W-1:0]   nblk_q, nblk_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [5:0]        coef_q, coef_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [TAG_W-1:0]  tag_q;
    logic              pend_q, done_q, done_d, cfg_err_q, cfg_err_d;

    logic              rd_en, pop, room, legal, blk_wrap, is_last;
    logic [1:0]        fifo_cnt;
    logic [PAY_W-1:0]  head;
    logic [ADDR_W-1:0] addr;

    assign legal    = (block_num_i != 32'd0) && (block_num_i <= 32'(MAX_BLOCKS));
    assign blk_wrap = ({1'b0, blk_q} == (nblk_q - NB_W'(1)));
    assign is_last  = blk_wrap && (coef_q == 6'd63);
    assign addr     = base_q + ADDR_W'({blk_q, 6'd0}) + ADDR_W'(scan_pos(coef_q));

    assign out_valid_o = (fifo_cnt != 2'd0);
    assign pop         = out_valid_o && out_ready_i;
    // Buffered + in flight after this cycle's pop must leave a slot for the new read.
    assign room = ({1'b0, fifo_cnt} + {2'b0, pend_q}) < (3'd2 + {2'b0, pop});

    always_comb begin
        state_d   = state_q;
        nblk_d    = nblk_q;
        base_d    = base_q;
        coef_d    = coef_q;
        blk_d     = blk_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (legal) begin
                    state_d = RUN;
                    nblk_d  = block_num_i[NB_W-1:0];
                    base_d  = base_addr_i;
                    coef_d  = 6'(FIRST_COEF);
                    blk_d   = '0;
                end else begin
                    done_d    = 1'b1;
                    cfg_err_d = 1'b1;
                end
            end
            RUN: if (room) begin
                rd_en = 1'b1;
                if (blk_wrap) begin
                    blk_d  = '0;
                    coef_d = coef_q + 6'd1;
                    if (coef_q == 6'd63) state_d = DRAIN;
                end else begin
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            DRAIN: if (pop && head[PAY_W-1]) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            nblk_q    <= '0;
            base_q    <= '0;
            coef_q    <= '0;
            blk_q     <= '0;
            tag_q     <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nblk_q    <= nblk_d;
            base_q    <= base_d;
            coef_q    <= coef_d;
            blk_q     <= blk_d;
            pend_q    <= rd_en;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            if (rd_en) tag_q <= {is_last, blk_q, coef_q};
        end
    end

    sync_fifo2 #(.W(PAY_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pend_q),
        .pop_i   (pop),
        .din_i   ({tag_q, rd_data_i}),
        .dout_o  (head),
        .count_o (fifo_cnt)
    );

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
    assign rd_en_o     = rd_en;
    assign rd_addr_o   = rd_en ? addr : '0;
    assign out_data_o  = head[DATA_W-1:0];
    assign out_coef_o  = head[DATA_W +: 6];
    assign out_block_o = head[DATA_W+6 +: BLK_W];
    assign out_last_o  = head[PAY_W-1];

endmodule

// File: tb/tb_ac_scan_reader.sv
// Randomized bench for ac_scan_reader against a scan-order scoreboard model.
module tb_ac_scan_reader;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int BW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start_b;
    logic [31:0]   block_num, block_num_b;
    logic [AW-1:0] base_addr, base_addr_b;
    logic          busy, done, cfg_err, rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid, out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [5:0]    out_coef;
    logic [BW-1:0] out_block;
    logic          out_last;
    logic          busy_b, done_b, cfg_err_b, rd_en_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b;
    logic          out_valid_b, out_ready_b;
    logic [DW-1:0] out_data_b;
    logic [5:0]    out_coef_b;
    logic [BW-1:0] out_block_b;
    logic          out_last_b;

    ac_scan_reader u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .block_num_i(block_num),
        .base_addr_i(base_addr), .busy_o(busy), .done_o(done), .cfg_err_o(cfg_err),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_coef_o(out_coef), .out_block_o(out_block), .out_last_o(out_last)
    );

    ac_scan_reader #(.FIRST_COEF(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .block_num_i(block_num_b),
        .base_addr_i(base_addr_b), .busy_o(busy_b), .done_o(done_b), .cfg_err_o(cfg_err_b),
        .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b),
        .out_coef_o(out_coef_b), .out_block_o(out_block_b), .out_last_o(out_last_b)
    );

    // RAM word = its own address; junk when not read so stray timing shows up.
    always @(posedge clk) begin
        rd_data   <= rd_en   ? DW'(rd_addr)   : 32'hDEAD_BEEF;
        rd_data_b <= rd_en_b ? DW'(rd_addr_b) : 32'hDEAD_BEEF;
    end

    int scan_t [64] = '{
         0,  1,  8,  9,  2,  3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
         4,  5, 12, 20, 13,  6,  7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
        32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
        51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef struct {
        int  data;
        int  coef;
        int  blk;
        bit  last;
    } beat_t;

    beat_t exp_q [$];
    int    n_chk, n_fail, cyc, beats, last_pop_cyc, issued, popped, rmode;
    bit    mon_en, stall_prev;
    logic [43:0] prev_pay;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic build_exp(input int n, input int base, input int fc);
        exp_q.delete();
        for (int c = fc; c < 64; c++)
            for (int b = 0; b < n; b++)
                exp_q.push_back('{(base + b*64 + scan_t[c]) % 2048, c, b, (c == 63 && b == n-1)});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) if (mon_en) begin
        beat_t e;
        if (stall_prev) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'({out_data, out_coef, out_block, out_last}), 64'(prev_pay));
        end
        if (rd_en) issued++;
        if (out_valid && out_ready) begin
            popped++;
            beats++;
            if (exp_q.size() == 0) chk("extra_beat", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                chk("data", 64'(out_data), 64'(e.data));
                chk("coef", 64'(out_coef), 64'(e.coef));
                chk("block", 64'(out_block), 64'(e.blk));
                chk("last", 64'(out_last), 64'(e.last));
            end
            if (out_last) last_pop_cyc = cyc;
        end
        if (rd_en) chk("outstanding", 64'(issued - popped <= 2), 64'd1);
        stall_prev = out_valid && !out_ready;
        prev_pay   = {out_data, out_coef, out_block, out_last};
    end

    task automatic do_start(input int n, input int base);
        @(posedge clk); #1;
        start = 1'b1; block_num = n; base_addr = AW'(base);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_chk(input int n, input int base, input bit inj, input string tag);
        bit got = 0;
        bit bad = 0;
        int done_cyc = 0;
        build_exp(n, base, 1);
        beats = 0; issued = 0; popped = 0; stall_prev = 0; mon_en = 1;
        do_start(n, base);
        @(negedge clk);
        chk({tag, "_busy_t1"}, 64'(busy), 64'd1);
        chk({tag, "_rden_t1"}, 64'(rd_en), 64'd1);
        @(negedge clk);
        chk({tag, "_valid_t2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid_t3"}, 64'(out_valid), 64'd1);
        if (inj) begin
            @(posedge clk); #1; start = 1'b1; block_num = 4;
            @(posedge clk); #1; start = 1'b0;
        end
        for (int k = 0; k < 20000 && !got; k++) begin
            @(negedge clk);
            if (done) begin got = 1; done_cyc = cyc; end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_beats"}, 64'(beats), 64'(n * 63));
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_done_cyc"}, 64'(done_cyc), 64'(last_pop_cyc + 1));
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy || done || rd_en || out_valid) bad = 1;
        end
        chk({tag, "_idle_after"}, 64'(bad), 64'd0);
        mon_en = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        int k;
        rst = 1; start = 0; block_num = 0; base_addr = 0; rmode = 0;
        start_b = 0; block_num_b = 0; base_addr_b = 0; out_ready_b = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_coef", 64'(out_coef), 64'd0);
        chk("rst_block", 64'(out_block), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        #1 rst = 0;

        rmode = 0;
        run_chk(2, 0, 0, "normal");
        rmode = 1;
        run_chk(32, 256, 0, "bp32");

        for (int i = 0; i < 2; i++) begin
            int n = (i == 0) ? 0 : 33;
            bad = 0;
            do_start(n, 0);
            @(negedge clk);
            chk("ill_done", 64'(done), 64'd1);
            chk("ill_cfg_err", 64'(cfg_err), 64'd1);
            chk("ill_busy", 64'(busy), 64'd0);
            for (int j = 0; j < 6; j++) begin
                if (rd_en || out_valid || busy) bad = 1;
                @(negedge clk);
            end
            chk("ill_quiet", 64'(bad), 64'd0);
            chk("ill_done_once", 64'(done), 64'd0);
        end

        rmode = 0;
        run_chk(2, 0, 1, "ignore_start");

        rmode = 1;
        for (int i = 0; i < 3; i++)
            run_chk($urandom_range(1, 32), $urandom_range(0, 2047), 0, "rand");

        // Reset while stalled with both FIFO slots full.
        rmode = 2;
        do_start(4, 100);
        repeat (6) @(negedge clk);
        chk("stall_full_valid", 64'(out_valid), 64'd1);
        chk("stall_full_rden", 64'(rd_en), 64'd0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_rd_en", 64'(rd_en), 64'd0);
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_data", 64'(out_data), 64'd0);
        chk("mid_coef", 64'(out_coef), 64'd0);
        chk("mid_block", 64'(out_block), 64'd0);
        chk("mid_last", 64'(out_last), 64'd0);
        #1 rst = 0;
        rmode = 0;
        run_chk(3, 5, 0, "rerun");

        // DC-inclusive build, single block.
        @(posedge clk); #1; start_b = 1; block_num_b = 1; base_addr_b = 0;
        @(posedge clk); #1; start_b = 0;
        k = 0;
        bad = 0;
        for (int j = 0; j < 300 && !bad; j++) begin
            @(negedge clk);
            if (out_valid_b) begin
                chk("fc0_data", 64'(out_data_b), 64'(scan_t[k % 64]));
                chk("fc0_coef", 64'(out_coef_b), 64'(k % 64));
                chk("fc0_last", 64'(out_last_b), 64'(k == 63));
                k++;
            end
            if (done_b) bad = 1;
        end
        chk("fc0_done_seen", 64'(bad), 64'd1);
        chk("fc0_beats", 64'(k), 64'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
